// File: rtl/ll_pkg.sv
// Shared types and helpers for the link-list packet writer.
package ll_pkg;

    // Packet writer FSM states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ALLOC_REQ,
        ST_ALLOC_WAIT,
        ST_LINK_WR,
        ST_TERM_WR,
        ST_ENQ
    } state_t;

    // Stop-page marker: only the MSB of a dw-bit link value is set
    function automatic logic [31:0] stop_page(input int unsigned dw);
        return 32'(1) << (dw - 1);
    endfunction

    // Normal link value: page number with the stop MSB forced to 0
    function automatic logic [31:0] link_val(input int unsigned dw, input logic [31:0] page);
        return page & ~(32'(1) << (dw - 1));
    endfunction

endpackage

// File: rtl/ll_pkt_writer.sv
// Ingress packet builder: allocates pages for a descriptor, chains them with
// link writes ending in the stop page, then enqueues the head page.
// Optional counters are built when LL_PKT_STATS_EN is defined.
module ll_pkt_writer
    import ll_pkg::*;
#(
    parameter int unsigned lpsz  = 8,
    parameter int unsigned lpdsz = lpsz + 1,
    parameter int unsigned lenw  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pkt_srdy,
    output logic              pkt_drdy,
    input  logic [lenw-1:0]   pkt_len,
    output logic              par_srdy,
    input  logic              par_drdy,
    input  logic              parr_srdy,
    output logic              parr_drdy,
    input  logic [lpsz-1:0]   parr_page,
    output logic              lnp_srdy,
    input  logic              lnp_drdy,
    output logic [lpsz-1:0]   lnp_pnum,
    output logic [lpdsz-1:0]  lnp_pdata,
    output logic              op_srdy,
    input  logic              op_drdy,
    output logic [lpsz-1:0]   op_page
`ifdef LL_PKT_STATS_EN
    ,
    output logic [31:0]       stat_pkts,
    output logic [31:0]       stat_pages,
    output logic [15:0]       stat_drop
`endif
);

    localparam logic [lpdsz-1:0] STOP_PAGE = lpdsz'(stop_page(lpdsz));

    state_t            state, state_nxt;
    logic [lenw-1:0]   rem, rem_nxt;
    logic              first, first_nxt;
    logic [lpsz-1:0]   head, head_nxt;
    logic [lpsz-1:0]   prev, prev_nxt;
    logic [lpsz-1:0]   lnp_pnum_nxt;
    logic [lpdsz-1:0]  lnp_pdata_nxt;
    logic [lpsz-1:0]   op_page_nxt;

    logic pkt_xfer, par_xfer, parr_xfer, lnp_xfer, op_xfer;

    assign pkt_xfer  = pkt_srdy  & pkt_drdy;
    assign par_xfer  = par_srdy  & par_drdy;
    assign parr_xfer = parr_srdy & parr_drdy;
    assign lnp_xfer  = lnp_srdy  & lnp_drdy;
    assign op_xfer   = op_srdy   & op_drdy;

    // Next-state and next-datapath decode
    always_comb begin
        state_nxt     = state;
        rem_nxt       = rem;
        first_nxt     = first;
        head_nxt      = head;
        prev_nxt      = prev;
        lnp_pnum_nxt  = lnp_pnum;
        lnp_pdata_nxt = lnp_pdata;
        op_page_nxt   = op_page;

        case (state)
            ST_IDLE: begin
                if (pkt_xfer && (pkt_len != '0)) begin
                    rem_nxt   = pkt_len;
                    first_nxt = 1'b1;
                    state_nxt = ST_ALLOC_REQ;
                end
            end
            ST_ALLOC_REQ: begin
                if (par_xfer) begin
                    state_nxt = ST_ALLOC_WAIT;
                end
            end
            ST_ALLOC_WAIT: begin
                if (parr_xfer) begin
                    if (rem != '0) begin
                        rem_nxt = rem - lenw'(1);
                    end
                    prev_nxt = parr_page;
                    if (first) begin
                        head_nxt  = parr_page;
                        first_nxt = 1'b0;
                        if (rem == lenw'(1)) begin
                            lnp_pnum_nxt  = parr_page;
                            lnp_pdata_nxt = STOP_PAGE;
                            state_nxt     = ST_TERM_WR;
                        end else begin
                            state_nxt = ST_ALLOC_REQ;
                        end
                    end else begin
                        lnp_pnum_nxt  = prev;
                        lnp_pdata_nxt = lpdsz'(link_val(lpdsz, 32'(parr_page)));
                        state_nxt     = ST_LINK_WR;
                    end
                end
            end
            ST_LINK_WR: begin
                if (lnp_xfer) begin
                    if (rem == '0) begin
                        lnp_pnum_nxt  = prev;
                        lnp_pdata_nxt = STOP_PAGE;
                        state_nxt     = ST_TERM_WR;
                    end else begin
                        state_nxt = ST_ALLOC_REQ;
                    end
                end
            end
            ST_TERM_WR: begin
                if (lnp_xfer) begin
                    op_page_nxt = head;
                    state_nxt   = ST_ENQ;
                end
            end
            ST_ENQ: begin
                if (op_xfer) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            rem       <= '0;
            first     <= 1'b0;
            head      <= '0;
            prev      <= '0;
            lnp_pnum  <= '0;
            lnp_pdata <= '0;
            op_page   <= '0;
            pkt_drdy  <= 1'b0;
            par_srdy  <= 1'b0;
            parr_drdy <= 1'b0;
            lnp_srdy  <= 1'b0;
            op_srdy   <= 1'b0;
        end else begin
            state     <= state_nxt;
            rem       <= rem_nxt;
            first     <= first_nxt;
            head      <= head_nxt;
            prev      <= prev_nxt;
            lnp_pnum  <= lnp_pnum_nxt;
            lnp_pdata <= lnp_pdata_nxt;
            op_page   <= op_page_nxt;
            pkt_drdy  <= (state_nxt == ST_IDLE);
            par_srdy  <= (state_nxt == ST_ALLOC_REQ);
            parr_drdy <= (state_nxt == ST_ALLOC_WAIT);
            lnp_srdy  <= (state_nxt == ST_LINK_WR) || (state_nxt == ST_TERM_WR);
            op_srdy   <= (state_nxt == ST_ENQ);
        end
    end

`ifdef LL_PKT_STATS_EN
    // Free-running packet, page and dropped-descriptor counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_pkts  <= '0;
            stat_pages <= '0;
            stat_drop  <= '0;
        end else begin
            if (op_xfer) begin
                stat_pkts <= stat_pkts + 32'd1;
            end
            if (parr_xfer) begin
                stat_pages <= stat_pages + 32'd1;
            end
            if ((state == ST_IDLE) && pkt_xfer && (pkt_len == '0)) begin
                stat_drop <= stat_drop + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ll_pkt_writer.sv
// Directed scoreboard bench for ll_pkt_writer (stats checked when LL_PKT_STATS_EN is defined).
module tb_ll_pkt_writer;

    localparam int unsigned LPSZ  = 8;
    localparam int unsigned LPDSZ = 9;
    localparam int unsigned LENW  = 6;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              pkt_srdy = 1'b0;
    logic              pkt_drdy;
    logic [LENW-1:0]   pkt_len = '0;
    logic              par_srdy;
    logic              par_drdy = 1'b0;
    logic              parr_srdy = 1'b0;
    logic              parr_drdy;
    logic [LPSZ-1:0]   parr_page = '0;
    logic              lnp_srdy;
    logic              lnp_drdy = 1'b0;
    logic [LPSZ-1:0]   lnp_pnum;
    logic [LPDSZ-1:0]  lnp_pdata;
    logic              op_srdy;
    logic              op_drdy = 1'b0;
    logic [LPSZ-1:0]   op_page;
`ifdef LL_PKT_STATS_EN
    logic [31:0]       stat_pkts;
    logic [31:0]       stat_pages;
    logic [15:0]       stat_drop;
`endif

    always #5 clk = ~clk;

    ll_pkt_writer #(.lpsz(LPSZ), .lpdsz(LPDSZ), .lenw(LENW)) dut (
        .clk       (clk),
        .reset     (reset),
        .pkt_srdy  (pkt_srdy),
        .pkt_drdy  (pkt_drdy),
        .pkt_len   (pkt_len),
        .par_srdy  (par_srdy),
        .par_drdy  (par_drdy),
        .parr_srdy (parr_srdy),
        .parr_drdy (parr_drdy),
        .parr_page (parr_page),
        .lnp_srdy  (lnp_srdy),
        .lnp_drdy  (lnp_drdy),
        .lnp_pnum  (lnp_pnum),
        .lnp_pdata (lnp_pdata),
        .op_srdy   (op_srdy),
        .op_drdy   (op_drdy),
        .op_page   (op_page)
`ifdef LL_PKT_STATS_EN
        ,
        .stat_pkts (stat_pkts),
        .stat_pages(stat_pages),
        .stat_drop (stat_drop)
`endif
    );

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    logic [LPSZ-1:0]        pg [8];
    logic [LPSZ+LPDSZ-1:0]  exp_lnp [$];
    logic [LPSZ-1:0]        exp_op  [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int new_wait(input bit stall);
        return stall ? int'($urandom_range(1, 10)) : 0;
    endfunction

    task automatic set_pages(input logic [LPSZ-1:0] a, input logic [LPSZ-1:0] b,
                             input logic [LPSZ-1:0] c, input logic [LPSZ-1:0] d);
        pg[0] = a; pg[1] = b; pg[2] = c; pg[3] = d;
        for (int i = 4; i < 8; i++) pg[i] = '0;
    endtask

    // Present a descriptor and hold it until accepted; entered and left at a negedge
    task automatic send_desc(input int len);
        int guard = 0;
        pkt_srdy = 1'b1;
        pkt_len  = LENW'(len);
        while (pkt_drdy !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("desc_accept_timeout", 64'(pkt_drdy), 64'(1));
        @(negedge clk);
        pkt_srdy = 1'b0;
        pkt_len  = '1;
    endtask

    // Run one packet through all handshakes, scoring link writes and the enqueue
    task automatic run_packet(input int len, input bit stall, input bit abort);
        int  n_alloc = 0;
        int  aidx = 0;
        int  cyc = 0;
        bit  done = 1'b0;
        bit  parr_pend = 1'b0;
        bit  hold_lnp = 1'b0;
        bit  hold_op = 1'b0;
        bit  px, rx, lx, ox;
        int  c_par, c_parr, c_lnp, c_op;
        logic [LPSZ-1:0]       last_pnum = '0;
        logic [LPDSZ-1:0]      last_pdata = '0;
        logic [LPSZ-1:0]       last_op = '0;
        logic [LPSZ+LPDSZ-1:0] e;
        logic [LPSZ-1:0]       eo;

        for (int i = 0; i < len - 1; i++)
            exp_lnp.push_back({pg[i], 1'b0, pg[i+1]});
        exp_lnp.push_back({pg[len-1], 1'b1, LPSZ'(0)});
        exp_op.push_back(pg[0]);

        c_par  = new_wait(stall);
        c_parr = new_wait(stall);
        c_lnp  = new_wait(stall);
        c_op   = new_wait(stall);
        send_desc(len);

        while (!done && cyc < 2000) begin
            if (hold_lnp)
                check("lnp_hold", 64'({lnp_srdy, lnp_pnum, lnp_pdata}), 64'({1'b1, last_pnum, last_pdata}));
            if (hold_op)
                check("op_hold", 64'({op_srdy, op_page}), 64'({1'b1, last_op}));
            check("pkt_drdy_busy", 64'(pkt_drdy), 64'(0));
            check("par_parr_excl", 64'(par_srdy & parr_drdy), 64'(0));

            if (abort && lnp_srdy && !lnp_pdata[LPDSZ-1]) begin
                par_drdy = 1'b0; parr_srdy = 1'b0; lnp_drdy = 1'b0; op_drdy = 1'b0;
                reset = 1'b0;
                #1;
                check("async_rst_srdy", 64'({pkt_drdy, par_srdy, parr_drdy, lnp_srdy, op_srdy}), 64'(0));
                check("async_rst_data", 64'({lnp_pnum, lnp_pdata, op_page}), 64'(0));
                exp_lnp.delete();
                exp_op.delete();
                return;
            end

            par_drdy = par_srdy && (c_par == 0);
            if (par_srdy && c_par > 0) c_par--;
            lnp_drdy = lnp_srdy && (c_lnp == 0);
            if (lnp_srdy && c_lnp > 0) c_lnp--;
            op_drdy = op_srdy && (c_op == 0);
            if (op_srdy && c_op > 0) c_op--;
            parr_srdy = parr_pend && (c_parr == 0);
            if (parr_pend && c_parr > 0) c_parr--;
            parr_page = (parr_srdy && aidx < 8) ? pg[aidx] : '0;

            px = par_srdy && par_drdy;
            rx = parr_srdy && parr_drdy;
            lx = lnp_srdy && lnp_drdy;
            ox = op_srdy && op_drdy;

            if (px) begin
                n_alloc++;
                parr_pend = 1'b1;
                c_par  = new_wait(stall);
                c_parr = new_wait(stall);
            end
            if (rx) begin
                parr_pend = 1'b0;
                aidx++;
            end
            if (lx) begin
                if (exp_lnp.size() == 0) begin
                    check("lnp_unexpected", 64'({lnp_pnum, lnp_pdata}), 64'(0));
                end else begin
                    e = exp_lnp.pop_front();
                    check("lnp_write", 64'({lnp_pnum, lnp_pdata}), 64'(e));
                end
                c_lnp = new_wait(stall);
            end
            if (ox) begin
                if (exp_op.size() == 0) begin
                    check("op_unexpected", 64'(op_page), 64'(0));
                end else begin
                    eo = exp_op.pop_front();
                    check("op_page", 64'(op_page), 64'(eo));
                end
                c_op = new_wait(stall);
                done = 1'b1;
            end

            hold_lnp   = lnp_srdy && !lx;
            hold_op    = op_srdy && !ox;
            last_pnum  = lnp_pnum;
            last_pdata = lnp_pdata;
            last_op    = op_page;
            cyc++;
            @(negedge clk);
        end

        par_drdy = 1'b0; parr_srdy = 1'b0; lnp_drdy = 1'b0; op_drdy = 1'b0;
        check("pkt_done_in_budget", 64'(done), 64'(1));
        check("alloc_count", 64'(n_alloc), 64'(len));
        check("lnp_all_seen", 64'(exp_lnp.size()), 64'(0));
        check("idle_after_enq", 64'(pkt_drdy), 64'(1));
        exp_lnp.delete();
        exp_op.delete();
    endtask

    // Zero-length descriptor: accepted and dropped with no other activity
    task automatic run_empty();
        send_desc(0);
        for (int i = 0; i < 6; i++) begin
            check("empty_no_activity", 64'({pkt_drdy, par_srdy, parr_drdy, lnp_srdy, op_srdy}), 64'(5'b10000));
            @(negedge clk);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        check("reset_srdy", 64'({pkt_drdy, par_srdy, parr_drdy, lnp_srdy, op_srdy}), 64'(0));
        check("reset_data", 64'({lnp_pnum, lnp_pdata, op_page}), 64'(0));
`ifdef LL_PKT_STATS_EN
        check("reset_stats", 64'({stat_pkts, stat_pages[15:0], stat_drop}), 64'(0));
`endif
        reset = 1'b1;
        @(negedge clk);
        check("idle_drdy", 64'(pkt_drdy), 64'(1));

        set_pages(8'd5, 8'd0, 8'd0, 8'd0);
        run_packet(1, 1'b0, 1'b0);

        set_pages(8'd7, 8'd2, 8'd9, 8'd0);
        run_packet(3, 1'b0, 1'b0);

        set_pages(8'd4, 8'd8, 8'd1, 8'd0);
        run_packet(3, 1'b1, 1'b0);

        run_empty();
        set_pages(8'd10, 8'd11, 8'd0, 8'd0);
        run_packet(2, 1'b0, 1'b0);

        set_pages(8'd20, 8'd21, 8'd22, 8'd23);
        run_packet(4, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check("held_rst_srdy", 64'({pkt_drdy, par_srdy, parr_drdy, lnp_srdy, op_srdy}), 64'(0));
        reset = 1'b1;
        @(negedge clk);
        set_pages(8'd3, 8'd0, 8'd0, 8'd0);
        run_packet(1, 1'b0, 1'b0);

        pulse_reset();
        run_empty();
        set_pages(8'd30, 8'd31, 8'd0, 8'd0);
        run_packet(2, 1'b1, 1'b0);
        set_pages(8'd32, 8'd0, 8'd0, 8'd0);
        run_packet(1, 1'b0, 1'b0);
        set_pages(8'd40, 8'd41, 8'd42, 8'd43);
        run_packet(4, 1'b0, 1'b0);
`ifdef LL_PKT_STATS_EN
        check("stat_pkts", 64'(stat_pkts), 64'(3));
        check("stat_pages", 64'(stat_pages), 64'(7));
        check("stat_drop", 64'(stat_drop), 64'(1));
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
